booth_divider: RTL
==================

// Module: booth_divider
// PURPOSE
//  Sequential signed integer divider, the inverse of the team's radix-4 Booth multiplier; same start/ack/busy/irq handshake.
//  Radix-2 restoring division on operand magnitudes, one quotient bit per cycle, with a final sign fix-up.
//  Truncates toward zero; the remainder takes the dividend's sign. Sits beside the multiplier on the same control interface.
// PARAMETERS
//  N_W  32  dividend and quotient width (even, >= 2*D_W)
//  D_W  16  divisor and remainder width
// PORTS
//  clk         in   1    global clock
//  reset       in   1    synchronous reset, active-high
//  start       in   1    rising edge requests a division
//  ack         in   1    clears irq and busy while in DONE
//  irq_enable  in   1    1: finish by raising irq and wait for ack; 0: finish straight to idle
//  dividend    in   N_W  signed dividend, sampled on the accepted start edge
//  divisor     in   D_W  signed divisor, sampled on the accepted start edge
//  busy        out  1    division in progress or awaiting ack
//  irq         out  1    completion interrupt
//  quotient    out  N_W  signed quotient, held until the next accepted start
//  remainder   out  D_W  signed remainder, held until the next accepted start
//  div_zero    out  1    last division had divisor == 0
//  overflow    out  1    last division was MIN/-1
// BEHAVIOUR
//  Clocking and reset
//   - One clock; all state updates on posedge clk.
//   - reset=1 at any edge, including mid-operation: state IDLE; busy, irq, quotient, remainder, div_zero and overflow all 0; start_q=0.
//  Start detection and operand capture
//   - start_q is registered start; start_pe = start & ~start_q.
//   - start_pe is acted on only in IDLE. Edges in any other state are ignored and not queued; a held-high start does not retrigger.
//   - On an accepted start, dividend and divisor are latched; later input changes have no effect.
//  FSM states
//   - IDLE: on start_pe -> PREP; busy<=1; div_zero<=0; overflow<=0.
//   - PREP (1 cycle): latch |dividend| into an (N_W+1)-bit magnitude and |divisor| into a (D_W+1)-bit magnitude; record sign_q = sa^sb and sign_r = sa; clear the partial remainder and the bit counter -> RUN.
//   - RUN (N_W cycles), each cycle:
//       pr = {pr, next dividend MSB}; trial = pr - |divisor|.
//       If trial >= 0: pr <= trial, shift in quotient bit 1; else keep pr, shift in 0.
//       After count N_W-1 -> FIX.
//   - FIX (1 cycle): write quotient/remainder, then negate the magnitudes per sign_q / sign_r.
//       If irq_enable: irq<=1 -> DONE. Else: busy<=0 -> IDLE.
//   - DONE: busy=1, irq=1. On ack: irq<=0, busy<=0 -> IDLE. ack is ignored in every other state.
//  Latency
//   - Accepted start at edge E0; outputs update at edge E0+N_W+2 (34 for defaults).
//   - Latency is fixed and independent of operand values, including the special cases below.
//  Special cases (override in FIX)
//   - divisor==0: quotient = all ones, remainder = dividend[D_W-1:0], div_zero=1.
//   - dividend == -2^(N_W-1) and divisor == -1: quotient = -2^(N_W-1) (wraps), remainder = 0, overflow=1.
//   - div_zero and overflow follow the same handshake as a normal result; both hold until the next accepted start.
//  Width rules
//   - Magnitude paths are one bit wider than the operand so that |MIN| is representable.
//   - |remainder| < |divisor| <= 2^(D_W-1), so the result always fits in D_W signed bits.
//  Simultaneous events
//   - irq_enable is sampled only in FIX.
//   - ack and start_pe in the same DONE cycle: ack is honoured; the start is dropped.
// TESTING
//  T1: 100 / 7, irq_enable=1 -> at E0+34 quotient=14, remainder=2, irq=1; ack -> busy=0 and irq=0 on the next edge.
//  T2: -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2; flags 0.
//  T3: 0x8000_0000 / 0xFFFF -> q=0x8000_0000, r=0, overflow=1; 0x8000_0000 / 0x7FFF -> q=-65538 (0xFFFE_FFFE), r=-2 (0xFFFE), overflow=0.
//  T4: 1234 / 0 -> q=0xFFFF_FFFF, r=0x04D2, div_zero=1, latency still 34.
//  T5: irq_enable=0 -> busy falls at E0+34 with irq never asserted; start held high for 100 cycles -> exactly one division;
//      start pulse while busy -> ignored; ack pulse outside DONE -> no effect.
//  T6: reset asserted at E0+10 -> next edge all outputs 0, state IDLE; a fresh start then yields a correct result.

Source files
------------

// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, sign fix-up at the end, start/ack/busy/irq handshake.
module booth_divider #(
  parameter int unsigned N_W = 32,
  parameter int unsigned D_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ack,
  input  logic           irq_enable,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           irq,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned C_W = $clog2(N_W);
  localparam int unsigned M_W = D_W + 1;
  localparam int unsigned P_W = D_W + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic           start_q;
  logic           start_pe;
  logic [N_W-1:0] dvd_l;
  logic [D_W-1:0] dsr_l;
  logic [N_W:0]   dvd_mag;
  logic [M_W-1:0] dsr_mag;
  logic [M_W-1:0] pr;
  logic [C_W-1:0] count;
  logic           sign_q;
  logic           sign_r;

  logic [N_W-1:0] dvd_abs;
  logic [M_W-1:0] dsr_abs;
  logic [P_W-1:0] pr_shift;
  logic [P_W-1:0] trial;
  logic [N_W-1:0] q_mag;
  logic [N_W-1:0] q_neg;
  logic [D_W-1:0] r_mag;
  logic [D_W-1:0] r_neg;
  logic           is_zero;
  logic           is_ovf;

  // dvd_mag holds the dividend left-aligned one bit up; quotient bits fill in from the LSB
  always_comb begin
    start_pe = start & ~start_q;
    dvd_abs  = dvd_l[N_W-1] ? (~dvd_l + N_W'(1)) : dvd_l;
    dsr_abs  = dsr_l[D_W-1] ? (~{1'b1, dsr_l} + M_W'(1)) : {1'b0, dsr_l};
    pr_shift = {pr, dvd_mag[N_W]};
    trial    = pr_shift - P_W'(dsr_mag);
    q_mag    = dvd_mag[N_W-1:0];
    q_neg    = ~q_mag + N_W'(1);
    r_mag    = pr[D_W-1:0];
    r_neg    = ~r_mag + D_W'(1);
    is_zero  = (dsr_l == '0);
    is_ovf   = (dvd_l == {1'b1, {(N_W-1){1'b0}}}) && (dsr_l == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_pe) state_nx = S_PREP;
      S_PREP:  state_nx = S_RUN;
      S_RUN:   if (count == C_W'(N_W - 1)) state_nx = S_FIX;
      S_FIX:   state_nx = irq_enable ? S_DONE : S_IDLE;
      S_DONE:  if (ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      busy      <= 1'b0;
      irq       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      dvd_l     <= '0;
      dsr_l     <= '0;
      dvd_mag   <= '0;
      dsr_mag   <= '0;
      pr        <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (start_pe) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            dvd_l    <= dividend;
            dsr_l    <= divisor;
          end
        end
        S_PREP: begin
          dvd_mag <= {dvd_abs, 1'b0};
          dsr_mag <= dsr_abs;
          sign_q  <= dvd_l[N_W-1] ^ dsr_l[D_W-1];
          sign_r  <= dvd_l[N_W-1];
          pr      <= '0;
          count   <= '0;
        end
        S_RUN: begin
          dvd_mag <= {dvd_mag[N_W-1:0], ~trial[P_W-1]};
          pr      <= trial[P_W-1] ? pr_shift[M_W-1:0] : trial[M_W-1:0];
          count   <= count + C_W'(1);
        end
        S_FIX: begin
          if (is_zero) begin
            quotient  <= '1;
            remainder <= dvd_l[D_W-1:0];
          end else if (is_ovf) begin
            quotient  <= {1'b1, {(N_W-1){1'b0}}};
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? q_neg : q_mag;
            remainder <= sign_r ? r_neg : r_mag;
          end
          div_zero <= is_zero;
          overflow <= is_ovf;
          if (irq_enable) irq  <= 1'b1;
          else            busy <= 1'b0;
        end
        S_DONE: begin
          if (ack) begin
            irq  <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
